uart_fifo_ctrl: RTL and testbench

Controller that sequences the UART FIFO's dual-port `fifo_ram` in the 8051 MCU core. It owns the write and read pointers and the full/empty/level accounting. It drives the RAM's write and read ports, and presents a valid/ready stream interface on each side. A one-entry output stage absorbs the RAM's one-cycle read latency, so `rd_data` is held stable while `rd_valid` is high.

---
 rtl/uart_fifo_ctrl.sv | 128 ++++++++++++
 tb/tb_uart_fifo_ctrl.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_fifo_ctrl.sv
// UART FIFO controller: pointer/level accounting around a dual-port RAM with a
// one-entry output stage. Define UART_FIFO_ERR_EN to build the sticky ovf_err flag.
module uart_fifo_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_WIDTH = 4,
    parameter int AFULL_LVL  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  ram_w_en,
    output logic [ADDR_WIDTH-1:0] ram_w_addr,
    output logic [DATA_WIDTH-1:0] ram_w_data,
    output logic                  ram_r_en,
    output logic [ADDR_WIDTH-1:0] ram_r_addr,
    input  logic [DATA_WIDTH-1:0] ram_r_data,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  almost_full,
    output logic                  ovf_err,
    input  logic                  err_clr
);
    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH+1)'(FIFO_DEPTH);
    localparam logic [ADDR_WIDTH:0] AFULL_P  = (ADDR_WIDTH+1)'(AFULL_LVL);

    typedef enum logic [1:0] {S_EMPTY, S_FETCH, S_VALID} state_t;

    state_t              state, state_nxt;
    logic [ADDR_WIDTH:0] wp, rp, wp_nxt, rp_nxt, ram_cnt, level_nxt;
    logic                clr, ram_empty, wr_fire, rd_issue;

    assign clr       = rst | flush;
    assign ram_cnt   = wp - rp;
    assign ram_empty = (wp == rp);
    assign wr_ready  = (ram_cnt != FULL_CNT);
    assign wr_fire   = wr_valid & wr_ready & ~clr;

    assign ram_w_en   = wr_fire;
    assign ram_w_addr = wp[ADDR_WIDTH-1:0];
    assign ram_w_data = wr_data;
    assign ram_r_en   = rd_issue;
    assign ram_r_addr = rp[ADDR_WIDTH-1:0];
    assign rd_valid   = (state == S_VALID);

    always_comb begin
        state_nxt = state;
        rd_issue  = 1'b0;
        unique case (state)
            S_EMPTY: begin
                if (!ram_empty) begin
                    rd_issue  = 1'b1;
                    state_nxt = S_FETCH;
                end
            end
            S_FETCH: state_nxt = S_VALID;
            S_VALID: begin
                if (rd_ready) begin
                    if (!ram_empty) begin
                        rd_issue  = 1'b1;
                        state_nxt = S_FETCH;
                    end else begin
                        state_nxt = S_EMPTY;
                    end
                end
            end
            default: state_nxt = S_EMPTY;
        endcase
        // flush/reset abandon any in-flight read, including one in FETCH
        if (clr) begin
            rd_issue  = 1'b0;
            state_nxt = S_EMPTY;
        end
    end

    always_comb begin
        wp_nxt    = wp + {{ADDR_WIDTH{1'b0}}, wr_fire};
        rp_nxt    = rp + {{ADDR_WIDTH{1'b0}}, rd_issue};
        if (clr) begin
            wp_nxt = '0;
            rp_nxt = '0;
        end
        level_nxt = (wp_nxt - rp_nxt)
                  + {{ADDR_WIDTH{1'b0}}, (state_nxt != S_EMPTY)};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_EMPTY;
            wp          <= '0;
            rp          <= '0;
            level       <= '0;
            almost_full <= 1'b0;
            rd_data     <= '0;
        end else begin
            state       <= state_nxt;
            wp          <= wp_nxt;
            rp          <= rp_nxt;
            level       <= level_nxt;
            almost_full <= (level_nxt >= AFULL_P);
            if (flush)
                rd_data <= '0;
            else if (state == S_FETCH)
                rd_data <= ram_r_data;
        end
    end

`ifdef UART_FIFO_ERR_EN
    always_ff @(posedge clk) begin
        if (clr)
            ovf_err <= 1'b0;
        else if (wr_valid && !wr_ready)
            ovf_err <= 1'b1;
        else if (err_clr)
            ovf_err <= 1'b0;
    end
`else
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
    assign ovf_err        = 1'b0;
`endif

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// Bench for uart_fifo_ctrl: RAM model, queue-based reference model,
// directed scenarios followed by randomized traffic.
module tb_uart_fifo_ctrl;
    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int AFULL = 12;
`ifdef UART_FIFO_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst, flush, wr_valid, rd_ready, err_clr;
    logic [DW-1:0] wr_data;
    logic          wr_ready, rd_valid, ram_w_en, ram_r_en, almost_full, ovf_err;
    logic [DW-1:0] rd_data, ram_w_data, ram_r_data;
    logic [AW-1:0] ram_w_addr, ram_r_addr;
    logic [AW:0]   level;

    uart_fifo_ctrl #(
        .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH), .ADDR_WIDTH(AW), .AFULL_LVL(AFULL)
    ) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .ram_w_en(ram_w_en), .ram_w_addr(ram_w_addr), .ram_w_data(ram_w_data),
        .ram_r_en(ram_r_en), .ram_r_addr(ram_r_addr), .ram_r_data(ram_r_data),
        .level(level), .almost_full(almost_full),
        .ovf_err(ovf_err), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_w_en) mem[ram_w_addr] <= ram_w_data;
        if (ram_r_en) ram_r_data <= mem[ram_r_addr];
    end

    // reference model: RAM contents as a queue plus the output stage
    logic [DW-1:0] q[$];
    bit            st_occ;
    int            st_wait;
    logic [DW-1:0] st_data;
    bit            m_ovf;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_update();
        bit full_pre;
        if (rst || flush) begin
            q.delete();
            st_occ  = 0;
            st_wait = 0;
            m_ovf   = 0;
        end else begin
            full_pre = (q.size() == DEPTH);
            if (ERR_EN) begin
                if (wr_valid && full_pre) m_ovf = 1;
                else if (err_clr) m_ovf = 0;
            end
            if (st_occ && st_wait > 0) begin
                st_wait--;
            end else if (st_occ && rd_ready) begin
                if (q.size() > 0) begin
                    st_data = q.pop_front();
                    st_wait = 1;
                end else begin
                    st_occ = 0;
                end
            end else if (!st_occ && q.size() > 0) begin
                st_data = q.pop_front();
                st_occ  = 1;
                st_wait = 1;
            end
            if (wr_valid && !full_pre) q.push_back(wr_data);
        end
    endtask

    task automatic check_all();
        int  exp_lvl;
        bit  exp_vld;
        exp_lvl = q.size() + int'(st_occ);
        exp_vld = st_occ && (st_wait == 0);
        chk("level", 32'(level), 32'(exp_lvl));
        chk("wr_ready", 32'(wr_ready), 32'(q.size() != DEPTH));
        chk("almost_full", 32'(almost_full), 32'(exp_lvl >= AFULL));
        chk("rd_valid", 32'(rd_valid), 32'(exp_vld));
        if (exp_vld) chk("rd_data", 32'(rd_data), 32'(st_data));
        chk("ovf_err", 32'(ovf_err), 32'(m_ovf));
    endtask

    task automatic cyc();
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        wr_valid = 0;
        rd_ready = 0;
        for (int i = 0; i < n; i++) cyc();
    endtask

    logic [DW-1:0] got[$];

    initial begin
        rst = 1; flush = 0; wr_valid = 0; rd_ready = 0; err_clr = 0;
        wr_data = '0;
        st_occ = 0; st_wait = 0; st_data = '0; m_ovf = 0;
        cyc();
        cyc();
        chk("rst_rd_data", 32'(rd_data), 0);
        chk("rst_ram_w_en", 32'(ram_w_en), 0);
        chk("rst_ram_r_en", 32'(ram_r_en), 0);
        rst = 0;

        // single write, latency to rd_valid
        wr_valid = 1; wr_data = 8'hA5;
        cyc();
        wr_valid = 0;
        chk("lat_c1_r_en", 32'(ram_r_en), 1);
        cyc();
        chk("lat_c2_valid", 32'(rd_valid), 0);
        cyc();
        chk("lat_c3_valid", 32'(rd_valid), 1);
        chk("lat_c3_data", 32'(rd_data), 32'h A5);
        chk("lat_c3_level", 32'(level), 1);
        rd_ready = 1;
        cyc();
        rd_ready = 0;

        // fill: 17 writes back-to-back
        for (int i = 0; i <= 16; i++) begin
            wr_valid = 1; wr_data = DW'(i);
            cyc();
        end
        wr_valid = 0;
        chk("fill_level", 32'(level), 17);
        chk("fill_wr_ready", 32'(wr_ready), 0);
        chk("fill_afull", 32'(almost_full), 1);

        // write while full is dropped
        wr_valid = 1; wr_data = 8'hEE;
        cyc();
        wr_valid = 0;
        chk("ovf_set", 32'(ovf_err), 32'(ERR_EN));
        chk("ovf_level", 32'(level), 17);
        err_clr = 1;
        cyc();
        err_clr = 0;
        chk("ovf_clr", 32'(ovf_err), 0);

        // drain in order
        rd_ready = 1;
        for (int i = 0; i < 40; i++) begin
            if (rd_valid) got.push_back(rd_data);
            cyc();
        end
        rd_ready = 0;
        chk("drain_cnt", 32'(got.size()), 17);
        for (int i = 0; i < got.size(); i++)
            chk("drain_order", 32'(got[i]), 32'(i));

        // simultaneous write and consume with 3 held
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1; wr_data = DW'(8'h50 + i);
            cyc();
        end
        idle(3);
        chk("sim_pre_level", 32'(level), 3);
        wr_valid = 1; wr_data = 8'h53; rd_ready = 1;
        cyc();
        chk("sim_level", 32'(level), 3);
        wr_valid = 0;
        for (int i = 0; i < 10; i++) cyc();
        rd_ready = 0;

        // flush during FETCH with 5 held
        for (int i = 0; i < 6; i++) begin
            wr_valid = 1; wr_data = DW'(8'h60 + i);
            cyc();
        end
        idle(3);
        rd_ready = 1;
        cyc();
        rd_ready = 0;
        chk("pre_flush_level", 32'(level), 5);
        chk("pre_flush_valid", 32'(rd_valid), 0);
        flush = 1;
        cyc();
        flush = 0;
        chk("flush_level", 32'(level), 0);
        chk("flush_valid", 32'(rd_valid), 0);
        chk("flush_wr_ready", 32'(wr_ready), 1);
        wr_valid = 1; wr_data = 8'h3C;
        cyc();
        idle(3);
        chk("post_flush_data", 32'(rd_data), 32'h3C);
        chk("post_flush_valid", 32'(rd_valid), 1);

        // randomized traffic
        for (int i = 0; i < 1500; i++) begin
            wr_valid = ($urandom_range(0, 3) != 0);
            wr_data  = DW'($urandom);
            rd_ready = ($urandom_range(0, 2) == 0) || (i > 750 && i < 900);
            flush    = ($urandom_range(0, 99) == 0);
            err_clr  = ($urandom_range(0, 15) == 0);
            cyc();
        end
        wr_valid = 0; rd_ready = 0; flush = 0; err_clr = 0;
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
